// File: rtl/alu_div_pkg.sv
// Shared types and constants for the sequential ALU divider.
package alu_div_pkg;

    localparam int DIV_WIDTH = 8;

    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_t;

endpackage

// File: rtl/alu_addsub_w.sv
// N-bit ripple add/subtract: mode=1 inverts b and injects a carry-in of one, giving a - b.
module alu_addsub_w #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         mode,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N-1:0] bx;
    logic [N:0]   carry;

    assign bx       = b ^ {N{mode}};
    assign carry[0] = mode;

    // One full-adder cell per bit position.
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]     = a[i] ^ bx[i] ^ carry[i];
        assign carry[i+1] = (a[i] & bx[i]) | (carry[i] & (a[i] ^ bx[i]));
    end

    assign cout = carry[N];

endmodule

// File: rtl/alu_div8_seq.sv
// Sequential unsigned restoring divider: one shift-and-trial-subtract per clock,
// registered quotient/remainder with a single-cycle done pulse.
module alu_div8_seq
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] DBZ_Q = {WIDTH{DBZ_QUOTIENT[0]}};

    div_state_t       state, next_state;
    logic [WIDTH:0]   r, r_sh, trial, r_next;
    logic [WIDTH-1:0] q, q_next, d;
    logic [CW-1:0]    count;
    logic             no_borrow;
    logic             last;

    // The partial remainder keeps one extra bit so the trial subtract cannot overflow.
    assign r_sh   = (WIDTH+1)'({r, q[WIDTH-1]});
    assign last   = (count == CW'(WIDTH-1));
    assign r_next = no_borrow ? trial : r_sh;
    assign q_next = {q[WIDTH-2:0], no_borrow};

    alu_addsub_w #(.N(WIDTH+1)) u_trial (
        .a    (r_sh),
        .b    ({1'b0, d}),
        .mode (1'b1),
        .sum  (trial),
        .cout (no_borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start && divisor != '0) next_state = RUN;
            RUN:  if (last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    // Divide-by-zero resolves in IDLE without ever entering RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            count       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= DBZ_Q;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            d           <= divisor;
                            q           <= dividend;
                            r           <= '0;
                            count       <= '0;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    r     <= r_next;
                    q     <= q_next;
                    count <= count + 1'b1;
                    if (last) begin
                        quotient  <= q_next;
                        remainder <= r_next[WIDTH-1:0];
                        done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div8_seq.sv
// Self-checking bench for alu_div8_seq: arithmetic reference model plus directed vectors.
module tb_alu_div8_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    int tests = 0;
    int failed = 0;
    int done_count = 0;

    alu_div8_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference model: counts down the eight iteration cycles and produces
    // results with the / and % operators.
    int         m_left = 0;
    logic       m_done = 1'b0;
    logic       m_dbz = 1'b0;
    logic [7:0] m_q = '0, m_r = '0, m_pq = '0, m_pr = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_q    <= m_pq;
                    m_r    <= m_pr;
                    m_done <= 1'b1;
                end
            end else if (start) begin
                if (divisor == 0) begin
                    m_q    <= 8'hFF;
                    m_r    <= dividend;
                    m_dbz  <= 1'b1;
                    m_done <= 1'b1;
                end else begin
                    m_pq   <= dividend / divisor;
                    m_pr   <= dividend % divisor;
                    m_left <= 8;
                    m_dbz  <= 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model_busy", int'(busy), int'(m_left != 0));
        checkOutput("model_done", int'(done), int'(m_done));
        checkOutput("model_quotient", int'(quotient), int'(m_q));
        checkOutput("model_remainder", int'(remainder), int'(m_r));
        checkOutput("model_dbz", int'(div_by_zero), int'(m_dbz));
        if (done === 1'b1) done_count++;
    end

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    // Returns the number of clock edges after acceptance+2 until done is seen.
    task automatic waitDone(input int budget, output int edges);
        edges = 0;
        while (done !== 1'b1 && edges < budget) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (done !== 1'b1) begin
            tests++;
            failed++;
            $display("[TB] FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
    endtask

    task automatic runDiv(input string name, input logic [7:0] a, input logic [7:0] b,
                          input int eq, input int er, input int edbz, input int elat);
        int edges;
        applyStimulus(a, b);
        waitDone(12, edges);
        checkOutput({name, "_q"}, int'(quotient), eq);
        checkOutput({name, "_r"}, int'(remainder), er);
        checkOutput({name, "_dbz"}, int'(div_by_zero), edbz);
        checkOutput({name, "_latency"}, edges, elat);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

    logic [7:0] ev_a [4] = '{8'd255, 8'd5, 8'd255, 8'd0};
    logic [7:0] ev_b [4] = '{8'd1, 8'd9, 8'd255, 8'd3};
    int         ev_q [4] = '{255, 0, 1, 0};
    int         ev_r [4] = '{0, 5, 0, 0};

    initial begin
        int edges;
        int dc;
        @(posedge clk);
        #2;
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_quotient", int'(quotient), 0);
        checkOutput("reset_remainder", int'(remainder), 0);
        checkOutput("reset_dbz", int'(div_by_zero), 0);
        #5 rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Basic 100/7 with explicit busy/done timing.
        applyStimulus(8'd100, 8'd7);
        checkOutput("basic_busy_start", int'(busy), 1);
        repeat (7) @(posedge clk);
        #1;
        checkOutput("basic_busy_k7", int'(busy), 1);
        checkOutput("basic_done_k7", int'(done), 0);
        @(posedge clk);
        #1;
        checkOutput("basic_busy_k8", int'(busy), 0);
        checkOutput("basic_done_k8", int'(done), 1);
        checkOutput("basic_q", int'(quotient), 14);
        checkOutput("basic_r", int'(remainder), 2);
        checkOutput("basic_dbz", int'(div_by_zero), 0);

        // Back-to-back: new start in the done cycle, old results held meanwhile.
        applyStimulus(8'd50, 8'd6);
        checkOutput("b2b_busy", int'(busy), 1);
        checkOutput("b2b_held_q", int'(quotient), 14);
        checkOutput("b2b_held_r", int'(remainder), 2);
        waitDone(12, edges);
        checkOutput("b2b_q", int'(quotient), 8);
        checkOutput("b2b_r", int'(remainder), 2);
        checkOutput("b2b_latency", edges, 8);
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            runDiv($sformatf("edge%0d", i), ev_a[i], ev_b[i], ev_q[i], ev_r[i], 0, 8);
            @(posedge clk);
            #1;
        end

        // Divide by zero resolves at the accepting edge itself, never busy.
        runDiv("dbz", 8'd42, 8'd0, 255, 42, 1, 0);
        checkOutput("dbz_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        checkOutput("dbz_done_low", int'(done), 0);
        runDiv("after_dbz", 8'd9, 8'd3, 3, 0, 0, 8);
        @(posedge clk);
        #1;

        // Start while busy must be ignored.
        dc = done_count;
        applyStimulus(8'd200, 8'd10);
        dividend = 8'd7;
        divisor  = 8'd7;
        start    = 1'b1;
        repeat (4) @(posedge clk);
        #2 start = 1'b0;
        waitDone(12, edges);
        checkOutput("busy_ign_q", int'(quotient), 20);
        checkOutput("busy_ign_r", int'(remainder), 0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("busy_ign_done_pulses", done_count - dc, 1);

        // Asynchronous reset mid-run discards the division.
        applyStimulus(8'd100, 8'd7);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", int'(busy), 0);
        checkOutput("arst_done", int'(done), 0);
        checkOutput("arst_quotient", int'(quotient), 0);
        checkOutput("arst_remainder", int'(remainder), 0);
        checkOutput("arst_dbz", int'(div_by_zero), 0);
        dc = done_count;
        #10 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("arst_no_done", done_count - dc, 0);
        runDiv("after_rst", 8'd100, 8'd7, 14, 2, 0, 8);
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
